// File: rtl/if_stage_module_pkg.sv
// Shared widths and constants for the instruction-fetch stage and its IF/ID register.
package if_stage_module_pkg;

  localparam int unsigned ADDRESS_LEN     = 32;
  localparam int unsigned INSTRUCTION_LEN = 32;
  localparam logic [31:0] NOP_INSTRUCTION = 32'hE1A00000;  // MOV r0,r0

endpackage

// File: rtl/if_stage_module_reg.sv
// IF/ID pipeline register: flush beats freeze beats load; anything else is a bubble.
module if_stage_reg
  import if_stage_module_pkg::*;
#(
  parameter int unsigned             ADDR_W = ADDRESS_LEN,
  parameter int unsigned             INSTR_W = INSTRUCTION_LEN,
  parameter logic [INSTR_W-1:0]      NOP_INSTR = NOP_INSTRUCTION
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               freeze,
  input  logic               load,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               valid_out
);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;

  always_comb begin
    pc_d    = '0;
    instr_d = NOP_INSTR;
    valid_d = 1'b0;
    if (flush) begin
      pc_d    = '0;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (freeze) begin
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
    end else if (load) begin
      pc_d    = pc_in;
      instr_d = instr_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_out    = pc_q;
  assign instr_out = instr_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/if_stage_module.sv
// Instruction fetch: owns the PC, talks req/ack to instruction memory, feeds IF/ID register.
module if_stage_module
  import if_stage_module_pkg::*;
#(
  parameter int unsigned                    ADDR_W    = ADDRESS_LEN,
  parameter int unsigned                    INSTR_W   = INSTRUCTION_LEN,
  parameter logic [ADDR_W-1:0]              RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]             NOP_INSTR = NOP_INSTRUCTION
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_address,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  PC_out,
  output logic [INSTR_W-1:0] Instruction_out,
  output logic               valid_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic [ADDR_W-1:0]  hold_pc_q, hold_pc_d;
  logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;

  logic               reg_load;
  logic [ADDR_W-1:0]  reg_pc;
  logic [INSTR_W-1:0] reg_instr;
  logic [ADDR_W-1:0]  pc_plus4;

  assign pc_plus4 = pc_q + ADDR_W'(4);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    reg_load     = 1'b0;
    reg_pc       = pc_plus4;
    reg_instr    = imem_rdata;
    imem_req     = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          pc_d = branch_address;
          // Without an ack the address must stay put, so the in-flight fetch is drained first.
          if (imem_ack) req_addr_d = branch_address;
          else          state_d    = DISCARD;
        end else if (imem_ack) begin
          pc_d = pc_plus4;
          if (freeze) begin
            hold_pc_d    = pc_plus4;
            hold_instr_d = imem_rdata;
            state_d      = HOLD;
          end else begin
            reg_load   = 1'b1;
            req_addr_d = pc_plus4;
          end
        end
      end
      DISCARD: begin
        imem_req = 1'b1;
        if (branch_taken) pc_d = branch_address;
        if (imem_ack) begin
          req_addr_d = branch_taken ? branch_address : pc_q;
          state_d    = REQ;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_d       = branch_address;
          req_addr_d = branch_address;
          state_d    = REQ;
        end else if (!freeze) begin
          reg_load   = 1'b1;
          reg_pc     = hold_pc_q;
          reg_instr  = hold_instr_q;
          req_addr_d = pc_q;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  assign imem_addr = req_addr_q;

  if_stage_reg #(
    .ADDR_W    (ADDR_W),
    .INSTR_W   (INSTR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch_taken),
    .freeze    (freeze),
    .load      (reg_load),
    .pc_in     (reg_pc),
    .instr_in  (reg_instr),
    .pc_out    (PC_out),
    .instr_out (Instruction_out),
    .valid_out (valid_out)
  );

endmodule

// File: doc/if_stage_module.md
Name: if_stage_module

Overview:
- Instruction-fetch stage of the 5-stage ARM pipeline; sits directly upstream of the decode stage and supplies its PC_in / Instruction_in.
- Owns the program counter and fetches from an external instruction memory over a req/ack handshake that tolerates variable latency.
- Registers the fetched instruction in the IF/ID pipeline register.
- Honours freeze from the hazard unit and branch redirect/flush from the execute stage.

Parameters:
ADDRESS_LEN, 32, PC / memory address width
INSTRUCTION_LEN, 32, instruction width
RESET_PC, 0, PC value loaded at reset
NOP_INSTRUCTION, 32'hE1A00000, bubble inserted on flush or stall (MOV r0,r0)

Ports:
clk  in  1  sole clock, rising edge
rst  in  1  reset; asynchronous, active-low
freeze  in  1  hazard stall; hold the IF/ID register and do not advance the pipeline
branch_taken  in  1  redirect from execute; flush and refetch
branch_address  in  ADDRESS_LEN  redirect target
imem_req  out  1  fetch request, held until ack
imem_addr  out  ADDRESS_LEN  fetch address, stable while imem_req=1
imem_ack  in  1  one-cycle pulse; imem_rdata valid this cycle
imem_rdata  in  INSTRUCTION_LEN  fetched instruction
PC_out  out  ADDRESS_LEN  address of instruction + 4
Instruction_out  out  INSTRUCTION_LEN  instruction to decode
valid_out  out  1  Instruction_out is a real instruction

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst.
- Reset values:
  - pc = RESET_PC; req_addr = RESET_PC; state = IDLE.
  - imem_req = 0; PC_out = 0; Instruction_out = NOP_INSTRUCTION; valid_out = 0; hold buffer cleared.
- FSM states are IDLE, REQ, DISCARD and HOLD.
- IDLE:
  - Lasts one cycle after reset deassertion, then goes to REQ.
  - imem_req = 0; imem_ack is ignored.
- REQ:
  - imem_req = 1 and imem_addr = req_addr (= pc).
  - No ack: stay in REQ. The IF/ID register bubbles (NOP, valid 0) unless freeze=1, in which case it holds.
  - Ack, freeze=0, no branch: IF/ID register <= {pc+4, imem_rdata, valid 1}; pc, req_addr <= pc+4; stay in REQ.
  - Ack, freeze=1: capture imem_rdata and pc+4 in the hold buffer; pc <= pc+4; go to HOLD with imem_req=0.
  - branch_taken without ack: pc <= branch_address; req_addr unchanged (the address must stay stable); go to DISCARD.
  - branch_taken with ack: drop the data; pc, req_addr <= branch_address; stay in REQ.
- DISCARD:
  - imem_req = 1 on the old req_addr.
  - On ack: drop the data; req_addr <= pc; go to REQ.
  - A further branch_taken here updates pc only.
- HOLD:
  - imem_req = 0.
  - freeze=0: IF/ID register <= buffer, valid 1; req_addr <= pc; go to REQ.
  - branch_taken: drop the buffer; pc, req_addr <= branch_address; go to REQ.
- IF/ID register priority, per cycle: flush (branch_taken) > freeze (hold) > load > bubble.
  - Flush forces Instruction_out = NOP_INSTRUCTION and valid_out = 0, even while freeze=1.
- Timing:
  - Latency with a zero-wait memory (ack in the same cycle as req): the instruction appears on the outputs one edge later.
  - Sustained throughput is 1 instruction per cycle.
- pc arithmetic wraps modulo 2^ADDRESS_LEN; 0xFFFFFFFC + 4 = 0.
- Reset asserted mid-request abandons the transaction. The memory is reset by the same rst, so no stale ack is expected; any ack seen in IDLE is ignored.

Decomposition:
- ADDRESS_LEN, INSTRUCTION_LEN and NOP_INSTRUCTION go in the shared Defines.v include.
- FSM state encodings are local to this module.
- One sub-module: if_stage_reg, the IF/ID pipeline register with flush/freeze priority and async active-low reset. It mirrors the existing stage-register pattern.

Test Plan:
- Reset, then a zero-wait memory returning 0xE3A01005 at address 0: imem_addr sequence 0,4,8; one edge after the first ack, PC_out=4, Instruction_out=0xE3A01005, valid_out=1.
- 3-cycle memory latency: imem_addr stays 0x10 for 3 cycles; valid_out=0 with NOP during the wait; then PC_out=0x14.
- freeze=1 for 4 cycles arriving with an ack at 0x20: the outputs hold the previous instruction, imem_req=0 in HOLD; on release the buffered instruction appears with PC_out=0x24, and the next imem_addr is 0x24.
- branch_taken=1 to 0x100 while a request to 0x40 is outstanding: imem_addr stays 0x40 until ack; the ack data is dropped; the next request is 0x100; valid_out=0 through the flush.
- branch_taken and freeze asserted together: Instruction_out=0xE1A00000 and valid_out=0 (flush wins); fetch resumes at branch_address.
- rst pulled low mid-DISCARD: all outputs return to reset values immediately; after release the first imem_addr is RESET_PC.
